// File: rtl/color_scan_scheduler.sv
// Colour-sensor scan scheduler: arbitrates two requesters and steps the photodiode filter
// through red/blue/green (plus clear when CLEAR_CHANNEL_EN is defined) with settle and count windows.
module color_scan_scheduler #(
    parameter int WINDOW = 240,
    parameter int SETTLE = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       req_a,
    input  logic       req_b,
    output logic       gnt_a,
    output logic       gnt_b,
    output logic       S0,
    output logic       S1,
    output logic       S2,
    output logic       S3,
    output logic       OE,
    output logic       cnt_clr,
    output logic       cnt_en,
    output logic [1:0] cnt_sel,
    output logic       busy,
    output logic       done
);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_GRANT  = 3'd1,
        ST_SETTLE = 3'd2,
        ST_COUNT  = 3'd3,
        ST_DONE   = 3'd4
    } state_t;

`ifdef CLEAR_CHANNEL_EN
    localparam logic [1:0] LAST_CH = 2'd3;
`else
    localparam logic [1:0] LAST_CH = 2'd2;
`endif

    localparam logic [9:0] WIN_LAST    = 10'(WINDOW - 1);
    localparam logic [9:0] SET_LAST    = 10'(SETTLE - 1);
    // The GRANT cycle doubles as the first red settle cycle, keeping latency at N*(SETTLE+WINDOW).
    localparam logic [9:0] SET_LAST_RD = 10'(SETTLE - 2);
    localparam bit         SKIP_SETTLE = (SETTLE == 1);

    function automatic logic [1:0] filter_sel(input logic [1:0] ch);
        case (ch)
            2'd0:    filter_sel = 2'b00;
            2'd1:    filter_sel = 2'b01;
            2'd2:    filter_sel = 2'b11;
            default: filter_sel = 2'b10;
        endcase
    endfunction

    state_t     state_q, state_d;
    logic [9:0] cnt_q, cnt_d;
    logic [1:0] ch_q, ch_d;
    logic       owner_b_q, owner_b_d;
    logic       last_b_q, last_b_d;
    logic       req_own;

    logic       gnt_a_q, gnt_a_d;
    logic       gnt_b_q, gnt_b_d;
    logic       busy_q, busy_d;
    logic       done_q, done_d;
    logic       cnt_en_q, cnt_en_d;
    logic       cnt_clr_q, cnt_clr_d;
    logic [1:0] cnt_sel_q, cnt_sel_d;
    logic [1:0] s23_q, s23_d;
    logic       s0_q, s1_q, oe_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            ch_q      <= '0;
            owner_b_q <= 1'b0;
            last_b_q  <= 1'b1;
            gnt_a_q   <= 1'b0;
            gnt_b_q   <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            cnt_en_q  <= 1'b0;
            cnt_clr_q <= 1'b0;
            cnt_sel_q <= 2'd0;
            s23_q     <= 2'b10;
            s0_q      <= 1'b1;
            s1_q      <= 1'b0;
            oe_q      <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            ch_q      <= ch_d;
            owner_b_q <= owner_b_d;
            last_b_q  <= last_b_d;
            gnt_a_q   <= gnt_a_d;
            gnt_b_q   <= gnt_b_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            cnt_en_q  <= cnt_en_d;
            cnt_clr_q <= cnt_clr_d;
            cnt_sel_q <= cnt_sel_d;
            s23_q     <= s23_d;
            s0_q      <= 1'b1;
            s1_q      <= 1'b0;
            oe_q      <= 1'b0;
        end
    end

    always_comb begin
        state_d   = state_q;
        ch_d      = ch_q;
        owner_b_d = owner_b_q;
        last_b_d  = last_b_q;
        req_own   = owner_b_q ? req_b : req_a;
        case (state_q)
            ST_IDLE: begin
                if (req_a || req_b) begin
                    state_d   = ST_GRANT;
                    owner_b_d = req_b && (!req_a || !last_b_q);
                    last_b_d  = owner_b_d;
                    ch_d      = 2'd0;
                end
            end
            ST_GRANT: begin
                if (!req_own)         state_d = ST_IDLE;
                else if (SKIP_SETTLE) state_d = ST_COUNT;
                else                  state_d = ST_SETTLE;
            end
            ST_SETTLE: begin
                if (!req_own) begin
                    state_d = ST_IDLE;
                end else if (cnt_q == ((ch_q == 2'd0) ? SET_LAST_RD : SET_LAST)) begin
                    state_d = ST_COUNT;
                end
            end
            ST_COUNT: begin
                if (!req_own) begin
                    state_d = ST_IDLE;
                end else if (cnt_q == WIN_LAST) begin
                    if (ch_q == LAST_CH) begin
                        state_d = ST_DONE;
                    end else begin
                        state_d = ST_SETTLE;
                        ch_d    = ch_q + 2'd1;
                    end
                end
            end
            ST_DONE:  state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
        if ((state_d == state_q) && ((state_q == ST_SETTLE) || (state_q == ST_COUNT)))
            cnt_d = cnt_q + 10'd1;
        else
            cnt_d = '0;
    end

    // Outputs are decoded from the next state so every pin comes straight from a flop.
    always_comb begin
        busy_d    = (state_d != ST_IDLE);
        gnt_a_d   = busy_d && !owner_b_d;
        gnt_b_d   = busy_d && owner_b_d;
        done_d    = (state_d == ST_DONE);
        cnt_en_d  = (state_d == ST_COUNT);
        cnt_clr_d = (state_d == ST_GRANT);
        cnt_sel_d = busy_d ? ch_d : 2'd0;
        s23_d     = busy_d ? filter_sel(ch_d) : 2'b10;
    end

    assign gnt_a   = gnt_a_q;
    assign gnt_b   = gnt_b_q;
    assign busy    = busy_q;
    assign done    = done_q;
    assign cnt_en  = cnt_en_q;
    assign cnt_clr = cnt_clr_q;
    assign cnt_sel = cnt_sel_q;
    assign S2      = s23_q[1];
    assign S3      = s23_q[0];
    assign S0      = s0_q;
    assign S1      = s1_q;
    assign OE      = oe_q;

endmodule

// File: tb/tb_color_scan_scheduler.sv
// Directed bench for color_scan_scheduler with a grant/done scoreboard and per-cycle window monitor.
module tb_color_scan_scheduler;

    localparam int WINDOW = 240;
    localparam int SETTLE = 4;
`ifdef CLEAR_CHANNEL_EN
    localparam int NCH = 4;
`else
    localparam int NCH = 3;
`endif
    localparam int LAT = NCH * (SETTLE + WINDOW);

    logic       clk, rst_n, req_a, req_b;
    logic       gnt_a, gnt_b, S0, S1, S2, S3, OE, cnt_clr, cnt_en, busy, done;
    logic [1:0] cnt_sel;

    color_scan_scheduler #(.WINDOW(WINDOW), .SETTLE(SETTLE)) dut (
        .clk(clk), .rst_n(rst_n), .req_a(req_a), .req_b(req_b),
        .gnt_a(gnt_a), .gnt_b(gnt_b), .S0(S0), .S1(S1), .S2(S2), .S3(S3), .OE(OE),
        .cnt_clr(cnt_clr), .cnt_en(cnt_en), .cnt_sel(cnt_sel), .busy(busy), .done(done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;
    int cyc = 0;

    initial forever begin
        @(posedge clk);
        cyc = cyc + 1;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [1:0] exp_filter(input logic [1:0] sel);
        case (sel)
            2'd0:    exp_filter = 2'b00;
            2'd1:    exp_filter = 2'b01;
            2'd2:    exp_filter = 2'b11;
            default: exp_filter = 2'b10;
        endcase
    endfunction

    typedef struct {
        logic b;
        logic completes;
    } exp_t;

    exp_t exp_q[$];
    exp_t cur;
    int   done_seen = 0;
    int   scans_ended = 0;

    // Monitor: scoreboard pop on grant, window/settle timing, per-cycle invariants.
    initial begin
        logic       prev_gnt, prev_en, prev_done, active, g;
        logic [1:0] prev_s23, prev_sel;
        int         gstart, lowrun, runlen, chan_idx;
        prev_gnt = 0; prev_en = 0; prev_done = 0; active = 0;
        prev_s23 = 2'b10; prev_sel = 0;
        gstart = 0; lowrun = 0; runlen = 0; chan_idx = 0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                exp_q.delete();
                active = 0; prev_gnt = 0; prev_en = 0; prev_done = 0;
            end else begin
                g = gnt_a | gnt_b;
                chk("mutex", 32'(gnt_a & gnt_b), 0);
                chk("busy_eq_gnt", 32'(busy), 32'(g));
                chk("s0_s1_oe", {S0, S1, OE}, 3'b100);
                chk("clr_pulse", 32'(cnt_clr), 32'(g && !prev_gnt));
                if (cnt_en) chk("filter_consistent", {S2, S3}, exp_filter(cnt_sel));
                if (cnt_en && prev_en) chk("stable_in_window", {S2, S3, cnt_sel}, {prev_s23, prev_sel});
`ifndef CLEAR_CHANNEL_EN
                chk("no_clear_channel", 32'(cnt_sel == 2'd3), 0);
`endif
                if (g && !prev_gnt) begin
                    chk("grant_expected", 32'(exp_q.size() != 0), 1);
                    if (exp_q.size() != 0) begin
                        cur = exp_q.pop_front();
                        active = 1;
                        chk("grant_who", 32'(gnt_b), 32'(cur.b));
                    end else begin
                        active = 0;
                    end
                    chk("grant_red", {S2, S3, cnt_sel}, 4'b0000);
                    gstart = cyc; lowrun = 0; runlen = 0; chan_idx = 0;
                end
                if (active && g) begin
                    if (cnt_en) begin
                        if (!prev_en) begin
                            chk("settle_gap", lowrun, SETTLE);
                            chk("channel_order", 32'(cnt_sel), chan_idx);
                        end
                        runlen++;
                    end else begin
                        if (prev_en) begin
                            chk("window_len", runlen, WINDOW);
                            chan_idx++; runlen = 0; lowrun = 0;
                        end
                        lowrun++;
                    end
                    if (done) begin
                        chk("done_expected", 32'(cur.completes), 1);
                        chk("latency", cyc - gstart, LAT);
                        chk("window_count", chan_idx, NCH);
                        done_seen++;
                    end
                end
                if (!g && prev_gnt && active) begin
                    if (!prev_done) chk("abort_expected", 32'(cur.completes), 0);
                    chk("idle_outputs", {S2, S3, cnt_en, busy, done, cnt_sel}, 7'b1000000);
                    active = 0;
                    scans_ended++;
                end
                prev_gnt = g; prev_en = cnt_en; prev_done = done;
                prev_s23 = {S2, S3}; prev_sel = cnt_sel;
            end
        end
    end

    task automatic wait_done(input int limit);
        int k = 0;
        do begin
            @(negedge clk);
            k++;
        end while (!done && k < limit);
        chk("done_timeout", 32'(done), 1);
    endtask

    task automatic wait_scans(input int n, input int limit);
        int k = 0;
        while (scans_ended < n && k < limit) begin
            @(negedge clk);
            k++;
        end
        chk("scan_count", scans_ended, n);
    endtask

    task automatic check_reset_outputs(input string tag);
        chk(tag, {gnt_a, gnt_b, busy, done, cnt_en, cnt_clr, cnt_sel, S0, S1, S2, S3, OE},
            {6'b000000, 2'b00, 5'b10100});
    endtask

    task automatic push_exp(input logic b, input logic completes);
        exp_t e;
        e.b = b;
        e.completes = completes;
        exp_q.push_back(e);
    endtask

    initial begin
        int k, ds;
        rst_n = 1'b0; req_a = 1'b0; req_b = 1'b0;
        repeat (3) @(negedge clk);
        check_reset_outputs("reset_values");
        rst_n = 1'b1;
        @(negedge clk);
        check_reset_outputs("idle_after_release");

        // Single A scan
        push_exp(1'b0, 1'b1);
        req_a = 1'b1;
        wait_done(2000);
        chk("done_owner_a", {gnt_a, gnt_b}, 2'b10);
        req_a = 1'b0;
        @(negedge clk);
        chk("gnt_a_low_after_done", {gnt_a, busy, S2, S3}, 4'b0010);
        wait_scans(1, 10);

        // Both requesting from reset: A, B, A, B
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        push_exp(1'b0, 1'b1); push_exp(1'b1, 1'b1);
        push_exp(1'b0, 1'b1); push_exp(1'b1, 1'b1);
        req_a = 1'b1; req_b = 1'b1;
        for (int i = 0; i < 4; i++) begin
            wait_done(2000);
            chk("alternate_owner", 32'(gnt_b), 32'(i % 2));
        end
        req_a = 1'b0; req_b = 1'b0;
        @(negedge clk);
        chk("idle_after_alternate", 32'(busy), 0);
        wait_scans(5, 10);

        // Abort A after 300 cycles, pending B served next
        push_exp(1'b0, 1'b0); push_exp(1'b1, 1'b1);
        req_a = 1'b1;
        k = 0;
        do begin @(negedge clk); k++; end while (!gnt_a && k < 50);
        chk("gnt_a_rise", 32'(gnt_a), 1);
        req_b = 1'b1;
        repeat (300) @(negedge clk);
        req_a = 1'b0;
        @(negedge clk);
        chk("abort_outputs", {gnt_a, gnt_b, cnt_en, done, S2, S3}, 6'b000010);
        wait_done(2000);
        chk("b_after_abort", {gnt_a, gnt_b}, 2'b01);
        req_b = 1'b0;
        wait_scans(7, 10);

        // Asynchronous reset during blue window
        push_exp(1'b1, 1'b1);
        req_b = 1'b1;
        k = 0;
        do begin @(negedge clk); k++; end while (!(cnt_en && cnt_sel == 2'd1) && k < 1000);
        chk("reach_blue", {cnt_en, cnt_sel}, 3'b101);
        repeat (10) @(negedge clk);
        #2 rst_n = 1'b0;
        #1 check_reset_outputs("async_reset_values");
        req_b = 1'b0;
        ds = done_seen;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (1000) @(negedge clk);
        chk("no_done_after_reset", done_seen, ds);
        check_reset_outputs("idle_after_reset_scan");

        // Solo B scan (four windows when the clear channel is built in)
        push_exp(1'b1, 1'b1);
        req_b = 1'b1;
        wait_done(2000);
        chk("done_owner_b", {gnt_a, gnt_b}, 2'b01);
        req_b = 1'b0;
        wait_scans(8, 10);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/color_scan_scheduler.md
COLOR_SCAN_SCHEDULER -- requirements
Module: color_scan_scheduler

Interface
REQ-001 Parameter WINDOW, 240, counting-window length in clk cycles per filter channel (legal 1..1023).
REQ-002 Parameter SETTLE, 4, post-filter-switch dead time in clk cycles before counting (legal 1..15).
REQ-003 clk  in  1  sole clock, all state on rising edge.
REQ-004 rst_n  in  1  asynchronous active-low reset.
REQ-005 req_a  in  1  scan request, requester A (navigation); held high until done or abandoned.
REQ-006 req_b  in  1  scan request, requester B (diagnostic); same rules as req_a.
REQ-007 gnt_a, gnt_b  out  1 each  grant; at most one high in any cycle.
REQ-008 S0, S1  out  1 each  sensor frequency scaling select.
REQ-009 S2, S3  out  1 each  sensor photodiode filter select.
REQ-010 OE  out  1  sensor output enable, active low.
REQ-011 cnt_clr  out  1  one-cycle clear pulse to the external edge counters.
REQ-012 cnt_en  out  1  edge-counter enable, high only inside a counting window.
REQ-013 cnt_sel  out  2  channel being counted: 0 red, 1 blue, 2 green, 3 clear.
REQ-014 busy  out  1  high while any grant is held.
REQ-015 done  out  1  one-cycle pulse, scan complete for the granted requester.

Function
REQ-016 All outputs registered; S0=1, S1=0, OE=0 at all times after reset.
REQ-017 States: IDLE, GRANT, SETTLE, COUNT, DONE.
REQ-018 IDLE: S2/S3=10 (no filter), gnt/busy/cnt_en/done low; any req high -> GRANT next cycle.
REQ-019 Arbitration round-robin: both req high in IDLE -> grant the requester not served last; after reset A wins first.
REQ-020 GRANT (1 cycle): chosen gnt and busy rise, cnt_clr=1, cnt_sel=0, S2/S3=00 (red) -> SETTLE.
REQ-021 SETTLE: SETTLE cycles, cnt_en=0 -> COUNT.
REQ-022 COUNT: WINDOW cycles, cnt_en=1; on last cycle advance channel red->blue(S2/S3=01, cnt_sel=1)->green(11, cnt_sel=2) and return to SETTLE; after green -> DONE.
REQ-023 Filter and cnt_sel change on the same edge cnt_en falls; never while cnt_en=1.
REQ-024 DONE (1 cycle): done=1, gnt held; next cycle -> IDLE, gnt/busy low, S2/S3=10.
REQ-025 Latency: gnt rise to done pulse = 3*(SETTLE+WINDOW) cycles (732 at defaults).
REQ-026 Granted req dropping before DONE: abort, next cycle IDLE, no done, cnt_en=0, S2/S3=10; last-served pointer still updated.
REQ-027 Non-granted req changes during a scan ignored; re-arbitrated in IDLE, minimum one IDLE cycle between scans.
REQ-028 Window/settle counter 10 bits, resets to 0 on every state entry; no wrap at legal parameter values.

Reset
REQ-029 rst_n low: immediately IDLE, gnt_a=gnt_b=busy=done=cnt_en=cnt_clr=0, cnt_sel=0, S0=1, S1=0, S2=1, S3=0, OE=0, last-served=B.
REQ-030 Reset mid-scan discards the scan; no done emitted; release resumes in IDLE.

Configuration
REQ-031 Macro CLEAR_CHANNEL_EN defined: fourth channel after green (S2/S3=10, cnt_sel=3, same SETTLE+WINDOW); latency 4*(SETTLE+WINDOW).
REQ-032 CLEAR_CHANNEL_EN undefined: three channels only; cnt_sel never 3.

Verification
REQ-033 Reset, req_a=1 held, defaults -> gnt_a rises, cnt_clr one pulse, cnt_en high 3 windows of 240 cycles separated by 4-cycle gaps, done at gnt+732, gnt_a low next cycle.
REQ-034 req_a=req_b=1 from reset -> A served first, then B after one IDLE cycle; repeat -> A, B alternate.
REQ-035 req_a dropped 300 cycles after gnt_a -> abort next cycle, no done, S2/S3=10, cnt_en=0; pending req_b granted next.
REQ-036 rst_n asserted during blue COUNT -> all outputs to reset values asynchronously, no done after release.
REQ-037 CLEAR_CHANNEL_EN defined, req_b=1 -> four windows, cnt_sel 0,1,2,3, done at gnt+976.
REQ-038 Check every cycle: cnt_en=1 implies S2/S3 and cnt_sel stable and consistent, gnt_a&gnt_b never 1.
